// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, stable-time glitch
// filter, selectable-edge Mealy tick, sticky pending flags and a maskable irq.
module multi_edge_detector #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     level,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clear,
    input  logic [WIDTH-1:0]     irq_en,
    output logic [WIDTH-1:0]     tick,
    output logic [WIDTH-1:0]     filtered,
    output logic [WIDTH-1:0]     pending,
    output logic                 irq
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            logic                   filt_reg;
            logic                   filt_next;
            logic [CW-1:0]          cnt_reg;
            logic [CW-1:0]          cnt_next;
            logic                   accept;
            logic                   pend_reg;

            if (SYNC_STAGES == 1) begin : g_sync1
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg <= '0;
                    else       sync_reg <= level[gi];
                end
            end else begin : g_syncn
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg <= '0;
                    else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], level[gi]};
                end
            end

            assign s = sync_reg[SYNC_STAGES-1];

            // State is (filt_reg, cnt_reg != 0): STABLE_LOW/PEND_HIGH/STABLE_HIGH/PEND_LOW.
            always_comb begin
                filt_next = filt_reg;
                cnt_next  = '0;
                accept    = 1'b0;
                if (s != filt_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        accept    = 1'b1;
                        filt_next = s;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    filt_reg <= 1'b0;
                    cnt_reg  <= '0;
                    pend_reg <= 1'b0;
                end else begin
                    filt_reg <= filt_next;
                    cnt_reg  <= cnt_next;
                    pend_reg <= tick[gi] | (pend_reg & ~clear[gi]);
                end
            end

            // Mode is only looked at in the accept cycle, so it may change mid-filter.
            assign tick[gi]     = accept & (s ? mode[2*gi] : mode[2*gi+1]);
            assign filtered[gi] = filt_reg;
            assign pending[gi]  = pend_reg;
        end
    endgenerate

    assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector: tick events are queued with their
// expected cycle when the level is driven, and checked every cycle.
module tb_multi_edge_detector;

    localparam int LAT = 5;

    logic        clk;
    logic        reset;
    logic [7:0]  level;
    logic [15:0] mode;
    logic [7:0]  clear;
    logic [7:0]  irq_en;
    logic [7:0]  tick;
    logic [7:0]  filtered;
    logic [7:0]  pending;
    logic        irq;

    int tests;
    int fails;
    int cyc;

    typedef struct {
        int         at;
        logic [7:0] mask;
    } exp_t;
    exp_t exp_q[$];

    multi_edge_detector dut (
        .clk      (clk),
        .reset    (reset),
        .level    (level),
        .mode     (mode),
        .clear    (clear),
        .irq_en   (irq_en),
        .tick     (tick),
        .filtered (filtered),
        .pending  (pending),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Queue a tick for the cycle in which the level driven now should be accepted.
    task automatic expect_tick(input logic [7:0] m);
        exp_t e;
        int   t;
        t = cyc + LAT;
        if (exp_q.size() > 0 && exp_q[exp_q.size()-1].at == t) begin
            e = exp_q[exp_q.size()-1];
            e.mask = e.mask | m;
            exp_q[exp_q.size()-1] = e;
        end else begin
            e.at   = t;
            e.mask = m;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_all();
        clear = 8'hFF;
        @(negedge clk);
        clear = 8'h00;
    endtask

    // Every cycle out of reset the tick vector must equal the queued event or zero.
    always @(negedge clk) begin
        logic [7:0] exp_tick;
        if (!reset) begin
            exp_tick = 8'h00;
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                exp_tick = exp_q[0].mask;
                void'(exp_q.pop_front());
            end
            check("tick", {24'd0, tick}, {24'd0, exp_tick});
        end
    end

    logic [1:0] mseq [4];

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        level  = 8'h00;
        clear  = 8'h00;
        irq_en = 8'hFF;
        mode   = 16'h0155;
        mseq   = '{2'b01, 2'b10, 2'b11, 2'b00};

        wait_cycles(2);
        check("rst_tick",     {24'd0, tick},     32'h0);
        check("rst_filtered", {24'd0, filtered}, 32'h0);
        check("rst_pending",  {24'd0, pending},  32'h0);
        check("rst_irq",      {31'd0, irq},      32'h0);
        reset = 1'b0;

        // Basic rising edge on ch0
        @(negedge clk);
        level[0] = 1'b1;
        expect_tick(8'h01);
        wait_cycles(LAT + 1);
        check("t1_filtered", {31'd0, filtered[0]}, 32'h1);
        check("t1_pending",  {31'd0, pending[0]},  32'h1);
        check("t1_irq",      {31'd0, irq},         32'h1);
        clear_all();
        check("t1_cleared",  {24'd0, pending},     32'h0);

        // Glitch rejection on ch1: 3-clock pulse rejected, 4-clock pulse accepted
        level[1] = 1'b1;
        wait_cycles(3);
        level[1] = 1'b0;
        wait_cycles(8);
        check("t2_short_filtered", {31'd0, filtered[1]}, 32'h0);
        check("t2_short_pending",  {31'd0, pending[1]},  32'h0);
        level[1] = 1'b1;
        expect_tick(8'h02);
        wait_cycles(4);
        level[1] = 1'b0;
        wait_cycles(10);
        check("t2_long_pending",  {31'd0, pending[1]},  32'h1);
        check("t2_long_filtered", {31'd0, filtered[1]}, 32'h0);

        // Mode coverage on ch2
        for (int k = 0; k < 4; k++) begin
            clear_all();
            mode[5:4] = mseq[k];
            level[2] = 1'b1;
            if (mseq[k][0]) expect_tick(8'h04);
            wait_cycles(8);
            check("t3_filtered_hi", {31'd0, filtered[2]}, 32'h1);
            level[2] = 1'b0;
            if (mseq[k][1]) expect_tick(8'h04);
            wait_cycles(8);
            check("t3_filtered_lo", {31'd0, filtered[2]}, 32'h0);
            check("t3_pending", {31'd0, pending[2]}, {31'd0, (mseq[k] != 2'b00)});
        end
        mode[5:4] = 2'b01;

        // Clear/set collision on ch3
        clear_all();
        mode[7:6] = 2'b11;
        level[3] = 1'b1;
        expect_tick(8'h08);
        wait_cycles(LAT + 1);
        check("t4_pending_set", {31'd0, pending[3]}, 32'h1);
        level[3] = 1'b0;
        expect_tick(8'h08);
        wait_cycles(LAT);
        clear[3] = 1'b1;
        @(negedge clk);
        check("t4_set_wins", {31'd0, pending[3]}, 32'h1);
        @(negedge clk);
        clear[3] = 1'b0;
        check("t4_cleared", {31'd0, pending[3]}, 32'h0);
        check("t4_irq",     {31'd0, irq},        32'h0);

        // Interrupt masking with pending = 8'h05
        level[0] = 1'b0;
        wait_cycles(8);
        clear_all();
        level[0] = 1'b1;
        level[2] = 1'b1;
        expect_tick(8'h05);
        wait_cycles(LAT + 1);
        check("t5_pending", {24'd0, pending}, 32'h05);
        irq_en = 8'h02;
        #1;
        check("t5_irq_masked", {31'd0, irq}, 32'h0);
        irq_en = 8'h04;
        #1;
        check("t5_irq_enabled", {31'd0, irq}, 32'h1);
        irq_en = 8'h00;
        #1;
        check("t5_irq_dropped", {31'd0, irq}, 32'h0);
        check("t5_pending_kept", {24'd0, pending}, 32'h05);

        // Async reset while ch4 is mid-filter
        @(negedge clk);
        irq_en = 8'hFF;
        level[4] = 1'b1;
        wait_cycles(4);
        reset = 1'b1;
        #1;
        check("t6_tick",     {24'd0, tick},     32'h0);
        check("t6_filtered", {24'd0, filtered}, 32'h0);
        check("t6_pending",  {24'd0, pending},  32'h0);
        check("t6_irq",      {31'd0, irq},      32'h0);
        wait_cycles(2);
        reset = 1'b0;
        expect_tick(8'h15);
        wait_cycles(8);
        check("t6_post_pending",  {24'd0, pending},  32'h15);
        check("t6_post_filtered", {24'd0, filtered}, 32'h15);
        check("t6_post_irq",      {31'd0, irq},      32'h1);

        wait_cycles(2);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
Parametrised, multi-channel successor to the single-bit rising-edge detector. It is intended for asynchronous level inputs such as buttons, external strobes and status lines. Each channel synchronises its input, rejects glitches shorter than a programmable stable time, and emits a one-cycle Mealy tick on a selectable edge type. Ticks are captured into sticky pending flags, which are combined into one maskable interrupt line for the host FSM/CPU.

Parameters:
WIDTH, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=1)
FILTER_CYCLES, 4, consecutive cycles the synchronised level must differ from the filtered level before a transition is accepted (>=1; 1 = no filtering)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
level  input  WIDTH  raw asynchronous channel inputs
mode  input  2*WIDTH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
clear  input  WIDTH  per-channel pending clear, synchronous, level-sensitive
irq_en  input  WIDTH  per-channel interrupt enable
tick  output  WIDTH  one-cycle edge pulse per channel (Mealy, combinational from state + mode)
filtered  output  WIDTH  debounced level per channel (registered)
pending  output  WIDTH  sticky edge flags (registered)
irq  output  1  OR of (pending & irq_en), combinational from registers

Behaviour:
- Reset (async, active-high): all sync flops 0, filtered 0, counters 0, pending 0. Consequently tick 0 and irq 0 while reset is held. Reset mid-filter discards the partial count; no tick is produced.
- Sync: s[i] is the output of a SYNC_STAGES-deep flop chain on level[i].
- Filter, per channel, per clock:
  - s==filtered: cnt<=0.
  - s!=filtered and cnt==FILTER_CYCLES-1 (the "accept cycle"): filtered<=s, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- Counter width is max(1, clog2(FILTER_CYCLES)); it never exceeds FILTER_CYCLES-1.
- Per-channel states (filtered, cnt!=0): STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
  - A glitch shorter than FILTER_CYCLES returns PEND_* to STABLE_* with no tick.
- Tick: asserted combinationally during the accept cycle only:
  - rising: accept with s=1, mode 01 or 11.
  - falling: accept with s=0, mode 10 or 11.
  - mode 00: filtered still tracks the input; tick never asserts.
  - mode is sampled in the accept cycle only; changing mode mid-filter is legal.
- Latency: input change registered at edge 0 → s changes after edge SYNC_STAGES-1 → tick high in the cycle after edge SYNC_STAGES+FILTER_CYCLES-2; filtered updates at the next edge. Defaults: tick in the cycle between edges 4 and 5.
- Tick width is exactly one clock per accepted transition, even if the level is held indefinitely.
- Pending: at each edge, pending[i] <= tick[i] | (pending[i] & ~clear[i]).
  - Set wins over a simultaneous clear.
  - Clear on an idle channel has no effect.
- irq = |(pending & irq_en). Masking does not clear pending; re-enabling re-raises irq.
- Channels are fully independent; simultaneous ticks on any number of channels are all captured.
- A level already high when reset is released is reported as a rising edge once it has been filtered.

Test Plan:
1. Defaults, mode=01 on ch0. Raise level[0] one cycle after reset release and hold → tick[0] high for exactly 1 cycle, 4 cycles after the first sync edge; filtered[0]=1 next cycle; pending[0]=1; irq=1 with irq_en[0]=1.
2. Glitch rejection, FILTER_CYCLES=4. Pulse level[1] high for 3 clocks → no tick, filtered[1] stays 0. Pulse for 4 clocks → one tick.
3. Mode coverage on ch2, driving 0→1→0 with ≥6-clock holds. Mode 01 → 1 tick on the rise. Mode 10 → 1 tick on the fall. Mode 11 → 2 ticks. Mode 00 → 0 ticks, filtered still toggles.
4. Clear/set collision: pending[3]=1, then assert clear[3] in the same cycle as a new tick[3] → pending[3] stays 1. Clear alone next cycle → pending[3]=0, irq=0.
5. Interrupt masking: pending=8'h05, irq_en=8'h02 → irq=0. Set irq_en=8'h04 → irq=1. Drop irq_en → irq=0, pending unchanged at 8'h05.
6. Async reset with ch4 in PEND_HIGH (cnt=2) → all outputs 0 immediately. After release with level held high → a fresh rising tick after the full sync+filter latency, with no early tick.
